mem_rmw_ctrl: RTL and testbench

Initiator-side controller for the single-port word memory (rw_en 1=write / 0=read, registered read data, one-cycle read latency). It accepts byte-addressed read/write requests with byte enables over a valid/ready interface and translates them into word accesses. Partial writes are done as read-modify-write. It sits between a core/bus-side requester and the memory instance, with one request outstanding at a time.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/byte_merge.sv | 28 ++
 rtl/mem_rmw_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_rmw_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory-side controllers: the controller state
// encoding and the byte-lane width used by all byte-enable paths.
package mem_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/byte_merge.sv
// byte_merge
// Purely combinational byte-lane merge. Lanes whose enable bit is set come
// from new_i, all other lanes keep the value from old_i.
// Ports:
//   old_i    [WIDTH]   existing word
//   new_i    [WIDTH]   incoming word, word-aligned lanes
//   be_i     [WIDTH/8] lane enables, bit i covers bits [8i+7:8i]
//   merged_o [WIDTH]   resulting word
module byte_merge
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]        old_i,
  input  logic [WIDTH-1:0]        new_i,
  input  logic [WIDTH/BYTE_W-1:0] be_i,
  output logic [WIDTH-1:0]        merged_o
);

  localparam int NB = WIDTH / BYTE_W;

  // One mux per byte lane, selected by that lane's enable.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign merged_o[i*BYTE_W +: BYTE_W] =
      be_i[i] ? new_i[i*BYTE_W +: BYTE_W] : old_i[i*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl
// Initiator-side controller for a single-port word memory with registered
// read data (one-cycle read latency). Accepts byte-addressed requests with
// byte enables, one outstanding at a time, and turns them into word
// accesses. Partial writes are performed as read-modify-write.
// Ports:
//   clk_i, aresetn_i           clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake
//   req_write_i, req_addr_i,
//   req_wdata_i, req_be_i      request fields, latched on acceptance
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o     read data (0 for writes/errors), misalignment flag
//   mem_rw_en_o, mem_addr_o,
//   mem_data_o                 registered memory controls (1=write)
//   mem_data_i                 registered read data from the memory
module mem_rmw_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                                              clk_i,
  input  logic                                              aresetn_i,
  input  logic                                              req_valid_i,
  output logic                                              req_ready_o,
  input  logic                                              req_write_i,
  input  logic [$clog2(DEPTH)+$clog2(WIDTH/BYTE_W)-1:0]     req_addr_i,
  input  logic [WIDTH-1:0]                                  req_wdata_i,
  input  logic [WIDTH/BYTE_W-1:0]                           req_be_i,
  output logic                                              rsp_valid_o,
  input  logic                                              rsp_ready_i,
  output logic [WIDTH-1:0]                                  rsp_rdata_o,
  output logic                                              rsp_err_o,
  output logic                                              mem_rw_en_o,
  output logic [$clog2(DEPTH)-1:0]                          mem_addr_o,
  output logic [WIDTH-1:0]                                  mem_data_o,
  input  logic [WIDTH-1:0]                                  mem_data_i
);

  localparam int NB  = WIDTH / BYTE_W;
  localparam int OFS = $clog2(NB);
  localparam int WA  = $clog2(DEPTH);
  localparam int AW  = WA + OFS;

  // Mask of the byte-offset bits; a mask keeps this valid even when OFS is 0.
  localparam logic [AW-1:0] OFS_MASK = AW'(NB - 1);

  ctrl_state_e       state_q, state_d;
  logic              write_q, write_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_rw_en_q, mem_rw_en_d;
  logic [WA-1:0]     mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_data_q, mem_data_d;
  logic [WIDTH-1:0]  merged;

  byte_merge #(.WIDTH(WIDTH)) u_byte_merge (
    .old_i    (mem_data_i),
    .new_i    (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );

  // Next-state and next-output computation. The write strobe defaults low so
  // it is only ever high for the single cycle spent in WR.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_rw_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          if ((req_addr_i & OFS_MASK) != '0) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            mem_addr_d = WA'(req_addr_i >> OFS);
            if (!req_write_i) begin
              state_d = RD;
            end else if (&req_be_i) begin
              mem_data_d  = req_wdata_i;
              mem_rw_en_d = 1'b1;
              state_d     = WR;
            end else if (req_be_i == '0) begin
              rsp_valid_d = 1'b1;
              state_d     = RESP;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (!write_q) begin
          rsp_rdata_d = mem_data_i;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          mem_data_d  = merged;
          mem_rw_en_d = 1'b1;
          state_d     = WR;
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and outputs are registered; reset abandons any request in
  // flight, including a pending write, and never produces a response for it.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_rw_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_rw_en_q <= mem_rw_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_rw_en_o = mem_rw_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
module tb_mem_rmw_ctrl;

   logic        clk_i;
   logic        aresetn_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [9:0]  req_addr_i;
   logic [31:0] req_wdata_i;
   logic [3:0]  req_be_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        mem_rw_en_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;

   int compared;
   int mismatched;

   mem_rmw_ctrl #(.DEPTH(256), .WIDTH(32)) dut (
      .clk_i       (clk_i),
      .aresetn_i   (aresetn_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_be_i    (req_be_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .mem_rw_en_o (mem_rw_en_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_data_i  (mem_data_i)
   );

   // 100 MHz free-running clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Single-port word memory with registered read data; also counts the
   // write strobes it sees and remembers where the last write went.
   logic [31:0] memArr [256];
   int          wrCount = 0;
   int          lastWrAddr = -1;
   always @(posedge clk_i) begin
      if (mem_rw_en_o) begin
         memArr[mem_addr_o] <= mem_data_o;
         wrCount = wrCount + 1;
         lastWrAddr = int'(mem_addr_o);
      end
      mem_data_i <= memArr[mem_addr_o];
   end

   typedef struct {
      logic        write;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
      int          expWrites;
      int          expWrAddr;
   } vec_t;

   vec_t vecs [15];

   // Compare one value and record the outcome
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one request, measure accept-to-response latency (the accept edge
   // counts as cycle 1), capture the response and complete the handshake
   task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] rdata,
                                output logic err, output int writes);
      int w0;
      @(negedge clk_i);
      w0          = wrCount;
      req_valid_i = 1'b1;
      req_write_i = v.write;
      req_addr_i  = v.addr;
      req_wdata_i = v.wdata;
      req_be_i    = v.be;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      rdata = rsp_rdata_o;
      err   = rsp_err_o;
      @(negedge clk_i);
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      writes = wrCount - w0;
   endtask

   // Fill the vector table; pre-loads are done as full writes through the DUT
   initial begin
      vecs[0]  = '{1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2, 1, 4};
      vecs[1]  = '{1'b0, 10'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 3, 0, -1};
      vecs[2]  = '{1'b1, 10'h010, 32'h00005500, 4'h2, 32'h0,        1'b0, 4, 1, 4};
      vecs[3]  = '{1'b0, 10'h010, 32'h0,        4'h0, 32'hDEAD55EF, 1'b0, 3, 0, -1};
      vecs[4]  = '{1'b0, 10'h013, 32'h0,        4'h0, 32'h0,        1'b1, 1, 0, -1};
      vecs[5]  = '{1'b1, 10'h020, 32'h12345678, 4'hF, 32'h0,        1'b0, 2, 1, 8};
      vecs[6]  = '{1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1, 0, -1};
      vecs[7]  = '{1'b0, 10'h020, 32'h0,        4'h0, 32'h12345678, 1'b0, 3, 0, -1};
      vecs[8]  = '{1'b1, 10'h022, 32'h11111111, 4'hF, 32'h0,        1'b1, 1, 0, -1};
      vecs[9]  = '{1'b1, 10'h020, 32'hAABBCCDD, 4'h9, 32'h0,        1'b0, 4, 1, 8};
      vecs[10] = '{1'b0, 10'h020, 32'h0,        4'h0, 32'hAA3456DD, 1'b0, 3, 0, -1};
      vecs[11] = '{1'b1, 10'h3FC, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, 2, 1, 255};
      vecs[12] = '{1'b0, 10'h3FC, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, 3, 0, -1};
      vecs[13] = '{1'b1, 10'h030, 32'hAAAAAAAA, 4'hF, 32'h0,        1'b0, 2, 1, 12};
      vecs[14] = '{1'b0, 10'h030, 32'h0,        4'h0, 32'hAAAAAAAA, 1'b0, 3, 0, -1};
   end

   // Main test sequence
   initial begin
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          writes;
      logic [31:0] heldData;
      int          w0;
      logic        staleSeen;

      compared    = 0;
      mismatched  = 0;
      aresetn_i   = 1'b0;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      req_be_i    = '0;
      rsp_ready_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      checkOutput("reset req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("reset rsp_rdata", rsp_rdata_o, 32'd0);
      checkOutput("reset rsp_err", 32'(rsp_err_o), 32'd0);
      checkOutput("reset mem_rw_en", 32'(mem_rw_en_o), 32'd0);
      checkOutput("reset mem_addr", 32'(mem_addr_o), 32'd0);
      checkOutput("reset mem_data", mem_data_o, 32'd0);
      @(negedge clk_i);
      aresetn_i = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i], lat, rdata, err, writes);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
         checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
         checkOutput($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d writes", i), 32'(writes), 32'(vecs[i].expWrites));
         if (vecs[i].expWrites == 1)
            checkOutput($sformatf("vec%0d wr_addr", i), 32'(lastWrAddr), 32'(vecs[i].expWrAddr));
         checkOutput($sformatf("vec%0d post_hs rsp_valid", i), 32'(rsp_valid_o), 32'd0);
         checkOutput($sformatf("vec%0d post_hs req_ready", i), 32'(req_ready_o), 32'd1);
         checkOutput($sformatf("vec%0d post_hs rdata", i), rsp_rdata_o, 32'd0);
      end

      // Response backpressure: read of 0x3FC held for 5 cycles while a
      // competing write request is offered and must be ignored
      @(negedge clk_i);
      w0          = wrCount;
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 10'h3FC;
      req_be_i    = 4'h0;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      checkOutput("bp latency", 32'(lat), 32'd3);
      heldData = rsp_rdata_o;
      checkOutput("bp rdata", heldData, 32'h0BADF00D);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         checkOutput($sformatf("bp c%0d rsp_valid", c), 32'(rsp_valid_o), 32'd1);
         checkOutput($sformatf("bp c%0d rdata", c), rsp_rdata_o, heldData);
         checkOutput($sformatf("bp c%0d req_ready", c), 32'(req_ready_o), 32'd0);
         req_valid_i = 1'b1;
         req_write_i = 1'b1;
         req_addr_i  = 10'h3FC;
         req_wdata_i = 32'h55555555;
         req_be_i    = 4'hF;
      end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b0;
      checkOutput("bp after hs rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("bp after hs req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("bp ignored write", 32'(wrCount - w0), 32'd0);

      // Reset asserted while a full write to 0x030 sits in WR
      @(negedge clk_i);
      w0          = wrCount;
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_addr_i  = 10'h030;
      req_wdata_i = 32'hDEADBEEF;
      req_be_i    = 4'hF;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      checkOutput("rst_wr in WR mem_rw_en", 32'(mem_rw_en_o), 32'd1);
      #1;
      aresetn_i = 1'b0;
      #1;
      checkOutput("rst_wr req_ready", 32'(req_ready_o), 32'd1);
      checkOutput("rst_wr rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rst_wr mem_rw_en", 32'(mem_rw_en_o), 32'd0);
      checkOutput("rst_wr mem_addr", 32'(mem_addr_o), 32'd0);
      checkOutput("rst_wr mem_data", mem_data_o, 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      aresetn_i = 1'b1;
      staleSeen = 1'b0;
      repeat (4) begin
         @(negedge clk_i);
         if (rsp_valid_o) staleSeen = 1'b1;
      end
      checkOutput("rst_wr stale response", 32'(staleSeen), 32'd0);
      checkOutput("rst_wr dropped write", 32'(wrCount - w0), 32'd0);
      applyStimulus(vecs[14], lat, rdata, err, writes);
      checkOutput("rst_wr readback latency", 32'(lat), 32'd3);
      checkOutput("rst_wr readback rdata", rdata, 32'hAAAAAAAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
